// File: rtl/wall_pkg.sv
// Shared types and constants for the scrolling-wall sequencer.
// Optional feature macro SCORE_EN is consumed by wall_seq_ctrl.
package wall_pkg;

  localparam int WALL_W   = 4;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int HOLE_H   = 50;

  localparam int COL_W = $clog2(WALL_W);
  localparam int ROW_W = $clog2(SCREEN_H);

  localparam logic [7:0] WALL_START  = 8'd160;
  localparam logic [6:0] HOLE_Y_RST  = 7'd35;
  localparam logic [6:0] HOLE_Y_MAX  = 7'(SCREEN_H - HOLE_H);
  localparam logic [2:0] WALL_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_POS = 3'd1,
    S_LATCH     = 3'd2,
    S_ERASE     = 3'd3,
    S_UPDATE    = 3'd4,
    S_DRAW      = 3'd5,
    S_WAIT_TICK = 3'd6
  } wall_state_e;

  typedef enum logic [1:0] {
    CMD_HOLD      = 2'd0,
    CMD_UPDATE    = 2'd1,
    CMD_RESET_POS = 2'd2
  } wall_cmd_e;

  // Keeps the whole hole inside the visible rows.
  function automatic logic [6:0] clamp_hole(input logic [6:0] y);
    return (y > HOLE_Y_MAX) ? HOLE_Y_MAX : y;
  endfunction

endpackage

// File: rtl/wall_scan_counter.sv
// Column-inner / row-outer pixel counter covering one WALL_W x SCREEN_H wall slice.
module wall_scan_counter
  import wall_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             adv_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             done_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WALL_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCREEN_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign done_o = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign col_o  = col_q;
  assign row_o  = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = done_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/wall_seq_ctrl.sv
// Per-frame erase / advance / redraw sequencer for the scrolling wall.
// Define SCORE_EN to add the wrap-counting score output.
module wall_seq_ctrl
  import wall_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        game_over,
  input  logic        frame_tick,
  input  logic [7:0]  wall_x_in,
  input  logic [6:0]  hole_y_in,
  output logic [1:0]  wall_cmd,
  output logic        vga_req,
  input  logic        vga_gnt,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  colour,
  output logic        busy,
  output logic        frame_overrun,
  output logic [6:0]  hole_y,
`ifdef SCORE_EN
  output logic [7:0]  score,
`endif
  output wall_state_e state_dbg
);

  wall_state_e state_q, state_d;
  wall_cmd_e   cmd;
  logic [6:0]  hole_y_q, hole_y_d;
  logic        overrun_q, overrun_d;

  logic             scanning;
  logic             on_screen;
  logic             in_hole;
  logic             scan_adv;
  logic             scan_done;
  logic             pass_done;
  logic [COL_W-1:0] scan_col;
  logic [ROW_W-1:0] scan_row;
  logic [8:0]       px_sum;
  logic [7:0]       row_ext;
  logic [7:0]       hole_lo;
  logic [7:0]       hole_hi;

  wall_scan_counter u_scan (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (!scanning),
    .adv_i   (scan_adv),
    .col_o   (scan_col),
    .row_o   (scan_row),
    .done_o  (scan_done)
  );

  // Columns are summed in 9 bits so a wall near the right edge is clipped, not wrapped.
  assign scanning  = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign px_sum    = {1'b0, wall_x_in} + 9'(scan_col);
  assign on_screen = (px_sum < 9'(SCREEN_W));
  assign scan_adv  = scanning && (!on_screen || vga_gnt);
  assign pass_done = scan_adv && scan_done;

  assign row_ext = 8'(scan_row);
  assign hole_lo = {1'b0, hole_y_q};
  assign hole_hi = hole_lo + 8'(HOLE_H);
  assign in_hole = (row_ext >= hole_lo) && (row_ext < hole_hi);

  always_comb begin
    state_d = state_q;
    cmd     = CMD_HOLD;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_RESET_POS;
      S_RESET_POS: begin
        cmd     = CMD_RESET_POS;
        state_d = S_LATCH;
      end
      S_LATCH:     state_d = S_DRAW;
      S_ERASE:     if (pass_done) state_d = S_UPDATE;
      S_UPDATE:    begin
        cmd     = CMD_UPDATE;
        state_d = S_LATCH;
      end
      S_DRAW:      if (pass_done) state_d = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (game_over)       state_d = S_IDLE;
        else if (frame_tick) state_d = S_ERASE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Plot outputs are functions of the held counter, so they stay put until the grant.
  always_comb begin
    vga_req = scanning && on_screen;
    plot_x  = scanning ? px_sum[7:0] : 8'd0;
    plot_y  = scanning ? scan_row : 7'd0;
    colour  = BG_COLOUR;
    if (state_q == S_DRAW && !in_hole) colour = WALL_COLOUR;
  end

  always_comb begin
    hole_y_d  = hole_y_q;
    overrun_d = overrun_q;
    if (state_q == S_LATCH && wall_x_in == WALL_START) hole_y_d = clamp_hole(hole_y_in);
    if (frame_tick && state_q != S_WAIT_TICK) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hole_y_q  <= HOLE_Y_RST;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hole_y_q  <= hole_y_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SCORE_EN
  logic [7:0] score_q, score_d;
  logic       from_upd_q;

  // Only a wrap reached through UPDATE scores; the start-of-game latch does not.
  always_comb begin
    score_d = score_q;
    if (state_q == S_RESET_POS) begin
      score_d = 8'd0;
    end else if (state_q == S_LATCH && from_upd_q && wall_x_in == WALL_START &&
                 score_q != 8'hFF) begin
      score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q    <= 8'd0;
      from_upd_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      from_upd_q <= (state_q == S_UPDATE);
    end
  end

  assign score = score_q;
`endif

  assign wall_cmd      = cmd;
  assign busy          = (state_q != S_IDLE) && (state_q != S_WAIT_TICK);
  assign frame_overrun = overrun_q;
  assign hole_y        = hole_y_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_wall_seq_ctrl.sv
// Directed bench for wall_seq_ctrl with a wall-datapath model and pixel scoreboard.
module tb_wall_seq_ctrl;
  import wall_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        game_over;
  logic        frame_tick;
  logic [7:0]  model_x = 8'd0;
  logic [6:0]  hole_y_in;
  logic [1:0]  wall_cmd;
  logic        vga_req;
  logic        vga_gnt = 1'b1;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  colour;
  logic        busy;
  logic        frame_overrun;
  logic [6:0]  hole_y;
  wall_state_e state_dbg;
`ifdef SCORE_EN
  logic [7:0]  score;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int write_cnt = 0;
  int req_cnt = 0;
  logic        gnt_toggle = 1'b0;
  logic        x_load = 1'b0;
  logic [7:0]  x_load_val = 8'd0;
  logic [17:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [18:0] hold_val;

  wall_seq_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .game_over     (game_over),
    .frame_tick    (frame_tick),
    .wall_x_in     (model_x),
    .hole_y_in     (hole_y_in),
    .wall_cmd      (wall_cmd),
    .vga_req       (vga_req),
    .vga_gnt       (vga_gnt),
    .plot_x        (plot_x),
    .plot_y        (plot_y),
    .colour        (colour),
    .busy          (busy),
    .frame_overrun (frame_overrun),
    .hole_y        (hole_y),
`ifdef SCORE_EN
    .score         (score),
`endif
    .state_dbg     (state_dbg)
  );

  // Clock / reset-independent environment
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    vga_gnt = gnt_toggle ? ~vga_gnt : 1'b1;
  end

  always @(posedge clk) begin
    if (x_load)                model_x <= x_load_val;
    else if (wall_cmd == 2'd2) model_x <= 8'd160;
    else if (wall_cmd == 2'd1) model_x <= (model_x == 8'd0) ? 8'd160 : model_x - 8'd4;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every granted pixel must be the next expected one
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("hold", {vga_req, plot_x, plot_y, colour}, hold_val);
      if (vga_req) begin
        req_cnt++;
        check("req_in_scan", (state_dbg == S_ERASE || state_dbg == S_DRAW), 1);
      end
      if (vga_req && vga_gnt) begin
        write_cnt++;
        check("pix", {plot_x, plot_y, colour}, (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF);
      end
      hold_pend = vga_req && !vga_gnt;
      hold_val  = {1'b1, plot_x, plot_y, colour};
    end
  end

  // Driver tasks
  task automatic push_pass(input int x, input bit draw, input int hole);
    for (int r = 0; r < 120; r++) begin
      for (int c = 0; c < 4; c++) begin
        int px;
        logic [2:0] col;
        px  = x + c;
        col = (draw && !(r >= hole && r < hole + 50)) ? 3'b010 : 3'b000;
        if (px < 160) exp_q.push_back({px[7:0], r[6:0], col});
      end
    end
  endtask

  task automatic wait_state(input wall_state_e tgt, input int max, output int cyc);
    cyc = 0;
    while (state_dbg !== tgt && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_state", state_dbg, tgt);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_x(input logic [7:0] v);
    x_load_val = v;
    x_load     = 1'b1;
    @(negedge clk);
    x_load     = 1'b0;
  endtask

  int cyc;

  initial begin
    reset = 1'b1; start = 1'b0; game_over = 1'b0; frame_tick = 1'b0; hole_y_in = 7'd30;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_cmd", wall_cmd, 0);
    check("rst_plot", {vga_req, plot_x, plot_y, colour}, 0);
    check("rst_flags", {busy, frame_overrun}, 0);
    check("rst_hole", hole_y, 35);
    reset = 1'b0;
    @(negedge clk);

    // 1: start, position reset, empty draw at x=160
    pulse_start();
    check("t1_state_rp", state_dbg, S_RESET_POS);
    check("t1_cmd_rp", wall_cmd, 2);
    check("t1_busy", busy, 1);
    req_cnt = 0;
    @(negedge clk);
    check("t1_state_latch", state_dbg, S_LATCH);
    check("t1_cmd_hold", wall_cmd, 0);
    @(negedge clk);
    check("t1_state_draw", state_dbg, S_DRAW);
    wait_state(S_WAIT_TICK, 600, cyc);
    check("t1_draw_len", cyc, 480);
    check("t1_reqs", req_cnt, 0);
    check("t1_hole", hole_y, 30);
    check("t1_idle_busy", busy, 0);
    pulse_start();
    check("t1_start_ignored", state_dbg, S_WAIT_TICK);

    // 2: full erase at 100, redraw at 96 with hole 30..79
    load_x(8'd100);
    push_pass(100, 0, 30);
    push_pass(96, 1, 30);
    write_cnt = 0;
    pulse_tick();
    check("t2_erase", state_dbg, S_ERASE);
    wait_state(S_UPDATE, 600, cyc);
    check("t2_erase_len", cyc, 480);
    check("t2_erase_writes", write_cnt, 480);
    check("t2_cmd_upd", wall_cmd, 1);
    wait_state(S_DRAW, 10, cyc);
    check("t2_upd_latch_len", cyc, 2);
    wait_state(S_WAIT_TICK, 600, cyc);
    check("t2_draw_len", cyc, 480);
    check("t2_writes", write_cnt, 960);
    check("t2_queue", exp_q.size(), 0);

    // 3: grant toggling every cycle
    gnt_toggle = 1'b1;
    push_pass(96, 0, 30);
    push_pass(92, 1, 30);
    write_cnt = 0;
    pulse_tick();
    wait_state(S_UPDATE, 1200, cyc);
    check("t3_erase_writes", write_cnt, 480);
    wait_state(S_WAIT_TICK, 1200, cyc);
    check("t3_writes", write_cnt, 960);
    check("t3_queue", exp_q.size(), 0);
    gnt_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // 4: right-edge clipping at 158
    load_x(8'd158);
    push_pass(158, 0, 30);
    push_pass(154, 1, 30);
    write_cnt = 0;
    req_cnt = 0;
    pulse_tick();
    wait_state(S_UPDATE, 600, cyc);
    check("t4_erase_len", cyc, 480);
    check("t4_erase_writes", write_cnt, 240);
    check("t4_erase_reqs", req_cnt, 240);
    wait_state(S_WAIT_TICK, 600, cyc);
    check("t4_writes", write_cnt, 720);
    check("t4_queue", exp_q.size(), 0);

    // 5: overrun during DRAW, then game_over beats frame_tick
    push_pass(154, 0, 30);
    push_pass(150, 1, 30);
    write_cnt = 0;
    pulse_tick();
    wait_state(S_DRAW, 600, cyc);
    check("t5_no_overrun_yet", frame_overrun, 0);
    pulse_tick();
    check("t5_overrun", frame_overrun, 1);
    wait_state(S_WAIT_TICK, 600, cyc);
    check("t5_writes", write_cnt, 960);
    check("t5_queue", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("t5_no_extra_erase", state_dbg, S_WAIT_TICK);
    check("t5_overrun_sticky", frame_overrun, 1);
    game_over = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    frame_tick = 1'b0;
    check("t5_game_over", state_dbg, S_IDLE);
    check("t5_idle_flags", {busy, frame_overrun}, 2'b01);

    // 6: restart, wrap with clamped hole, async reset mid-erase
    hole_y_in = 7'd10;
    pulse_start();
    wait_state(S_WAIT_TICK, 1000, cyc);
    check("t6_hole_restart", hole_y, 10);
`ifdef SCORE_EN
    check("t6_score0", score, 0);
`endif
    load_x(8'd0);
    hole_y_in = 7'd90;
    push_pass(0, 0, 10);
    write_cnt = 0;
    pulse_tick();
    wait_state(S_WAIT_TICK, 1200, cyc);
    check("t6_writes", write_cnt, 480);
    check("t6_hole_clamp", hole_y, 70);
    check("t6_queue", exp_q.size(), 0);
    check("t6_overrun_kept", frame_overrun, 1);
`ifdef SCORE_EN
    check("t6_score1", score, 1);
`endif
    load_x(8'd100);
    push_pass(100, 0, 70);
    pulse_tick();
    repeat (10) @(negedge clk);
    check("t6_mid_erase_req", vga_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_req", vga_req, 0);
    check("t6_async_state", state_dbg, S_IDLE);
    check("t6_async_flags", {busy, frame_overrun}, 0);
    check("t6_async_hole", hole_y, 35);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
